// File: rtl/biquad_coeff_loader.sv
// biquad_coeff_loader: double-buffered biquad coefficients, committed to the
// filter atomically only when it is idle and not starting a sample.
module biquad_coeff_loader #(
  parameter int COEFF_WIDTH = 24,
  parameter logic [COEFF_WIDTH-1:0] B0_RESET = 1 << (COEFF_WIDTH-2)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [2:0]             wr_addr_i,
  input  logic [COEFF_WIDTH-1:0] wr_data_i,
  input  logic                   commit_i,
  input  logic                   commit_reinit_i,
  input  logic                   filter_start_i,
  input  logic                   filter_busy_i,
  output logic [COEFF_WIDTH-1:0] b0_o,
  output logic [COEFF_WIDTH-1:0] b1_o,
  output logic [COEFF_WIDTH-1:0] b2_o,
  output logic [COEFF_WIDTH-1:0] a1_o,
  output logic [COEFF_WIDTH-1:0] a2_o,
  output logic                   reinit_o,
  output logic                   commit_pending_o,
  output logic                   commit_done_o,
  output logic                   wr_error_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, APPLY = 2'd2} state_e;
  localparam logic [4:0][COEFF_WIDTH-1:0] COEFF_RST = {{(4*COEFF_WIDTH){1'b0}}, B0_RESET};
  state_e state_q, state_d;
  logic [4:0][COEFF_WIDTH-1:0] sh_q, sh_d, act_q, act_d;
  logic rflag_q, rflag_d, reinit_q, reinit_d, pend_q, pend_d, done_q, done_d, err_q, err_d;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sh_q     <= COEFF_RST;
      act_q    <= COEFF_RST;
      rflag_q  <= 1'b0;
      reinit_q <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      act_q    <= act_d;
      rflag_q  <= rflag_d;
      reinit_q <= reinit_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    act_d    = act_q;
    rflag_d  = rflag_q;
    reinit_d = 1'b0;
    pend_d   = pend_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en_i && wr_addr_i <= 3'd4) sh_d[wr_addr_i] = wr_data_i;
        err_d = wr_en_i && wr_addr_i > 3'd4;
        if (commit_i) begin
          rflag_d = commit_reinit_i;
          pend_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        err_d = wr_en_i;
        // Swap only on a cycle the filter neither computes nor starts a sample.
        if (!filter_busy_i && !filter_start_i) begin
          act_d    = sh_q;
          pend_d   = 1'b0;
          done_d   = 1'b1;
          reinit_d = rflag_q;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        err_d   = wr_en_i;
        rflag_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        reinit_d = reinit_q;
        done_d   = done_q;
        err_d    = err_q;
        state_d  = IDLE;
      end
    endcase
  end
  assign b0_o             = act_q[0];
  assign b1_o             = act_q[1];
  assign b2_o             = act_q[2];
  assign a1_o             = act_q[3];
  assign a2_o             = act_q[4];
  assign reinit_o         = reinit_q;
  assign commit_pending_o = pend_q;
  assign commit_done_o    = done_q;
  assign wr_error_o       = err_q;
endmodule

// File: tb/tb_biquad_coeff_loader.sv
// tb_biquad_coeff_loader: vector table plus hand sequences for long waits and reset.
module tb_biquad_coeff_loader;
  typedef struct {
    logic [23:0] b0, b1, b2, a1, a2;
    logic err, pend, done, rei;
  } exp_t;
  typedef struct {
    logic we;
    logic [2:0] a;
    logic [23:0] d;
    logic c, ri, st, bz;
    exp_t e;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 1'b0, commit = 1'b0, reinit_req = 1'b0, start = 1'b0, busy = 1'b0;
  logic [2:0] addr = '0;
  logic [23:0] data = '0;
  logic [23:0] b0, b1, b2, a1, a2;
  logic reinit, pend, done, err;
  int checks = 0, failures = 0;
  exp_t sb[$];
  vec_t tbl[22];
  exp_t p, n1, n2, n3, n4;
  biquad_coeff_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(addr), .wr_data_i(data),
    .commit_i(commit), .commit_reinit_i(reinit_req), .filter_start_i(start), .filter_busy_i(busy),
    .b0_o(b0), .b1_o(b1), .b2_o(b2), .a1_o(a1), .a2_o(a2),
    .reinit_o(reinit), .commit_pending_o(pend), .commit_done_o(done), .wr_error_o(err)
  );
  always #5 clk = ~clk;
  function automatic exp_t ex(exp_t c, logic er, logic pe, logic dn, logic re);
    exp_t r = c;
    r.err = er; r.pend = pe; r.done = dn; r.rei = re;
    return r;
  endfunction
  function automatic vec_t mk(logic we, logic [2:0] a, logic [23:0] d, logic c, logic ri,
                              logic st, logic bz, exp_t e);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.c = c; v.ri = ri; v.st = st; v.bz = bz; v.e = e;
    return v;
  endfunction
  task automatic chk(string n, logic [23:0] act, logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask
  task automatic cmp_all(string tag, exp_t e);
    chk({tag, ".b0"}, b0, e.b0);
    chk({tag, ".b1"}, b1, e.b1);
    chk({tag, ".b2"}, b2, e.b2);
    chk({tag, ".a1"}, a1, e.a1);
    chk({tag, ".a2"}, a2, e.a2);
    chk({tag, ".wr_error"}, {23'd0, err}, {23'd0, e.err});
    chk({tag, ".pending"}, {23'd0, pend}, {23'd0, e.pend});
    chk({tag, ".done"}, {23'd0, done}, {23'd0, e.done});
    chk({tag, ".reinit"}, {23'd0, reinit}, {23'd0, e.rei});
  endtask
  task automatic apply(string tag, vec_t v);
    exp_t g;
    wr_en = v.we; addr = v.a; data = v.d; commit = v.c; reinit_req = v.ri; start = v.st; busy = v.bz;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    wr_en = 1'b0; commit = 1'b0; reinit_req = 1'b0; start = 1'b0; busy = 1'b0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty got=0 exp=1", tag);
    end else begin
      g = sb.pop_front();
      cmp_all(tag, g);
    end
  endtask
  initial begin
    p  = '{b0: 24'h400000, b1: 24'h0, b2: 24'h0, a1: 24'h0, a2: 24'h0, err: 0, pend: 0, done: 0, rei: 0};
    n1 = '{b0: 24'h100000, b1: 24'h200000, b2: 24'h100000, a1: 24'hC00000, a2: 24'h300000,
           err: 0, pend: 0, done: 0, rei: 0};
    n2 = n1; n2.b1 = 24'h050000;
    n3 = n2; n3.b2 = 24'h0AAAAA;
    n4 = p;  n4.b1 = 24'h123456;
    tbl[0]  = mk(1, 0, 24'h100000, 0, 0, 0, 0, p);
    tbl[1]  = mk(1, 1, 24'h200000, 0, 0, 0, 0, p);
    tbl[2]  = mk(1, 2, 24'h100000, 0, 0, 0, 0, p);
    tbl[3]  = mk(1, 3, 24'hC00000, 0, 0, 0, 0, p);
    tbl[4]  = mk(1, 4, 24'h300000, 1, 0, 0, 0, ex(p, 0, 1, 0, 0));
    tbl[5]  = mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n1, 0, 0, 1, 0));
    tbl[6]  = mk(0, 0, 24'h0, 0, 0, 0, 0, n1);
    tbl[7]  = mk(1, 6, 24'h000007, 0, 0, 0, 0, ex(n1, 1, 0, 0, 0));
    tbl[8]  = mk(0, 0, 24'h0, 0, 0, 0, 0, n1);
    tbl[9]  = mk(1, 1, 24'h050000, 1, 1, 0, 1, ex(n1, 0, 1, 0, 0));
    tbl[10] = mk(1, 1, 24'h777777, 0, 0, 0, 1, ex(n1, 1, 1, 0, 0));
    tbl[11] = mk(0, 0, 24'h0, 1, 0, 1, 1, ex(n1, 0, 1, 0, 0));
    tbl[12] = mk(0, 0, 24'h0, 0, 0, 1, 0, ex(n1, 0, 1, 0, 0));
    tbl[13] = mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n2, 0, 0, 1, 1));
    tbl[14] = mk(0, 0, 24'h0, 0, 0, 0, 0, n2);
    tbl[15] = mk(0, 0, 24'h0, 1, 0, 0, 0, ex(n2, 0, 1, 0, 0));
    tbl[16] = mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n2, 0, 0, 1, 0));
    tbl[17] = mk(1, 0, 24'h123456, 1, 1, 0, 0, ex(n2, 1, 0, 0, 0));
    tbl[18] = mk(0, 0, 24'h0, 0, 0, 0, 0, n2);
    tbl[19] = mk(0, 0, 24'h0, 1, 0, 0, 0, ex(n2, 0, 1, 0, 0));
    tbl[20] = mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n2, 0, 0, 1, 0));
    tbl[21] = mk(0, 0, 24'h0, 0, 0, 0, 0, n2);
    repeat (2) @(posedge clk);
    #1;
    cmp_all("in_reset", p);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cmp_all("after_release", p);
    for (int i = 0; i < 22; i++) apply($sformatf("tbl%0d", i), tbl[i]);
    apply("busy_commit", mk(1, 2, 24'h0AAAAA, 1, 1, 0, 1, ex(n2, 0, 1, 0, 0)));
    for (int i = 0; i < 9; i++) apply($sformatf("busy%0d", i), mk(0, 0, 24'h0, 0, 0, 0, 1, ex(n2, 0, 1, 0, 0)));
    apply("busy_fall", mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n3, 0, 0, 1, 1)));
    apply("busy_after", mk(0, 0, 24'h0, 0, 0, 0, 0, n3));
    apply("rst_wait", mk(1, 0, 24'h200000, 1, 0, 0, 1, ex(n3, 0, 1, 0, 0)));
    rst_n = 1'b0;
    #1;
    cmp_all("async_rst", p);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply($sformatf("post_rst%0d", i), mk(0, 0, 24'h0, 0, 0, 0, 0, p));
    apply("first_commit", mk(1, 1, 24'h123456, 1, 0, 0, 0, ex(p, 0, 1, 0, 0)));
    apply("first_apply", mk(0, 0, 24'h0, 0, 0, 0, 0, ex(n4, 0, 0, 1, 0)));
    chk("sb_drained", 24'(sb.size()), 24'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
